// File: rtl/key_matrix_scan_pkg.sv
// Shared constants, types and helpers for the 8x8 key matrix scanner.
// Event codes carry a press/release flag above a 6-bit key index.
package key_matrix_pkg;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int NKEYS     = ROWS * COLS;
  localparam int KEY_IDX_W = 6;
  localparam int EV_CODE_W = 7;

  // Field positions inside ev_code.
  localparam int EV_PRESS_BIT = 6;
  localparam int EV_IDX_MSB   = 5;
  localparam int EV_IDX_LSB   = 0;

  // Scan FSM encodings.
  localparam logic [0:0] SCAN_IDLE = 1'b0;
  localparam logic [0:0] SCAN_RUN  = 1'b1;

  typedef logic [EV_CODE_W-1:0] ev_code_t;
  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  function automatic logic [ROWS-1:0] row_onehot(input logic [2:0] ptr);
    logic [ROWS-1:0] v;
    v      = '0;
    v[ptr] = 1'b1;
    return v;
  endfunction

  function automatic ev_code_t make_ev(input logic press, input key_idx_t idx);
    return {press, idx};
  endfunction

endpackage

// File: rtl/key_matrix_scan_if.sv
// Key-change event channel between the scanner (master) and its consumer (slave).
interface key_matrix_scan_if;
  import key_matrix_pkg::*;

  // ev_code is meaningful and held stable while ev_valid=1; an event transfers
  // on a rising edge where ev_valid=1 and ev_ready=1. ev_ready may toggle freely.
  logic     ev_valid;
  logic     ev_ready;
  ev_code_t ev_code;

  modport master (output ev_valid, output ev_code, input  ev_ready);
  modport slave  (input  ev_valid, input  ev_code, output ev_ready);

endinterface

// File: rtl/key_matrix_scan_prio.sv
// Combinational lowest-set-bit finder over the 64-key difference vector.
module prio_enc64
  import key_matrix_pkg::*;
(
  input  logic [NKEYS-1:0]     vec,
  output logic [KEY_IDX_W-1:0] idx,
  output logic                 any
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = KEY_IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/key_matrix_scan.sv
// 8x8 key matrix scanner: row drive, column sampling, frame debounce and a
// valid/ready key-change event stream derived from keys versus reported state.
module key_matrix_scan
  import key_matrix_pkg::*;
#(
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [COLS-1:0]   column_in,
  output logic [ROWS-1:0]   row,
  output logic [NKEYS-1:0]  keys,
  output logic              frame_done,
  output logic [0:0]        scan_state,
  key_matrix_scan_if.master ev
);

  logic [COLS-1:0]      sync1, sync2;
  logic [2:0]           row_ptr;
  logic [7:0]           settle_cnt;
  logic [3:0]           match_cnt;
  logic [NKEYS-1:0]     raw_frame, prev_frame, raw_next;
  logic [3:0]           match_next;
  logic                 row_last, frame_end, load_keys;

  logic [NKEYS-1:0]     reported, diff;
  logic [KEY_IDX_W-1:0] diff_idx;
  logic                 diff_any;
  logic                 ev_valid_q;
  ev_code_t             ev_code_q;

  assign row_last  = (settle_cnt == 8'(SETTLE - 1));
  assign frame_end = en && (scan_state == SCAN_RUN) && row_last && (row_ptr == 3'd7);

  // Raw frame as it will look once the current row's sample lands.
  always_comb begin
    raw_next = raw_frame;
    raw_next[{row_ptr, 3'b000} +: COLS] = sync2;
  end

  always_comb begin
    match_next = '0;
    if (raw_next == prev_frame) begin
      match_next = (match_cnt == 4'(DEBOUNCE)) ? match_cnt : match_cnt + 4'd1;
    end
  end

  assign load_keys = ({1'b0, match_next} + 5'd1) >= 5'(DEBOUNCE);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      scan_state <= SCAN_IDLE;
      row        <= '0;
      row_ptr    <= '0;
      settle_cnt <= '0;
      match_cnt  <= '0;
      raw_frame  <= '0;
      prev_frame <= '0;
      keys       <= '0;
      frame_done <= 1'b0;
    end else begin
      sync1      <= column_in;
      sync2      <= sync1;
      frame_done <= frame_end;
      if (!en) begin
        // Going idle discards any partial frame; keys are retained.
        scan_state <= SCAN_IDLE;
        row        <= '0;
        row_ptr    <= '0;
        settle_cnt <= '0;
        match_cnt  <= '0;
        raw_frame  <= '0;
        prev_frame <= '0;
      end else if (scan_state == SCAN_IDLE) begin
        scan_state <= SCAN_RUN;
        row        <= row_onehot(3'd0);
        row_ptr    <= '0;
        settle_cnt <= '0;
      end else if (row_last) begin
        raw_frame  <= raw_next;
        row_ptr    <= row_ptr + 3'd1;
        row        <= row_onehot(row_ptr + 3'd1);
        settle_cnt <= '0;
        if (row_ptr == 3'd7) begin
          prev_frame <= raw_next;
          match_cnt  <= match_next;
          if (load_keys) keys <= raw_next;
        end
      end else begin
        settle_cnt <= settle_cnt + 8'd1;
      end
    end
  end

  assign diff = keys ^ reported;

  prio_enc64 u_prio (
    .vec (diff),
    .idx (diff_idx),
    .any (diff_any)
  );

  // An event, once raised, is frozen until accepted; diff is looked at again
  // only after ev_valid drops, which gives the one-event-per-two-cycles rate.
  always_ff @(posedge clock) begin
    if (reset) begin
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      reported   <= '0;
    end else if (ev_valid_q) begin
      if (ev.ev_ready) begin
        reported[ev_code_q[EV_IDX_MSB:EV_IDX_LSB]] <= ev_code_q[EV_PRESS_BIT];
        ev_valid_q <= 1'b0;
      end
    end else if (diff_any) begin
      ev_valid_q <= 1'b1;
      ev_code_q  <= make_ev(keys[diff_idx], diff_idx);
    end
  end

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_code  = ev_code_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan: scan timing, debounce, event stream and idle/reset.
module tb_key_matrix_scan;
  import key_matrix_pkg::*;

  localparam logic [63:0] K5  = 64'h0000_0000_0000_0020;
  localparam logic [63:0] K10 = 64'h0000_0000_0000_0400;
  localparam logic [63:0] K63 = 64'h8000_0000_0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  column_in;
  logic [7:0]  row;
  logic [63:0] keys;
  logic        frame_done;
  logic [0:0]  scan_state;
  logic [63:0] pressed;

  int tests_run    = 0;
  int tests_failed = 0;
  int ev_count     = 0;
  int base;
  int cyc;
  int hold_bad;
  int fd_seen;
  logic [7:0] exp_row;
  logic [6:0] exp_q[$];

  key_matrix_scan_if ev_if ();

  key_matrix_scan #(.SETTLE(4), .DEBOUNCE(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .column_in  (column_in),
    .row        (row),
    .keys       (keys),
    .frame_done (frame_done),
    .scan_state (scan_state),
    .ev         (ev_if.master)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // Physical matrix: a driven row shows its pressed keys on the columns.
  function automatic logic [7:0] matrix_cols(input logic [7:0] r, input logic [63:0] p);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) if (r[i]) c = c | p[8*i +: 8];
    return c;
  endfunction

  assign column_in = matrix_cols(row, pressed);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    en    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    en    = 1'b1;
  endtask

  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (frame_done !== 1'b1 && cycles < 40);
    check("frame_seen", 64'(frame_done), 64'd1);
  endtask

  task automatic wait_frames(input int n);
    int c;
    for (int i = 0; i < n; i++) wait_frame(c);
  endtask

  // scoreboard: every accepted event must match the head of exp_q
  always @(negedge clock) begin
    #1;
    if (ev_if.ev_valid === 1'b1 && ev_if.ev_ready === 1'b1) begin
      ev_count++;
      check("ev_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("ev_code", 64'(ev_if.ev_code), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    reset          = 1'b1;
    en             = 1'b0;
    pressed        = '0;
    ev_if.ev_ready = 1'b1;
    repeat (3) @(negedge clock);

    // reset state
    check("rst_row",      64'(row),           64'h0);
    check("rst_keys",     keys,               64'h0);
    check("rst_fd",       64'(frame_done),    64'h0);
    check("rst_valid",    64'(ev_if.ev_valid),64'h0);
    check("rst_code",     64'(ev_if.ev_code), 64'h0);
    check("rst_state",    64'(scan_state),    64'(SCAN_IDLE));

    // row stepping, 4 cycles per row, frame_done every 32 cycles
    reset = 1'b0;
    en    = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      exp_row = 8'h01 << (k / 4);
      check("t1_row", 64'(row), 64'(exp_row));
      check("t1_fd_low", 64'(frame_done), 64'h0);
    end
    @(negedge clock);
    check("t1_fd_pulse", 64'(frame_done), 64'h1);
    check("t1_row_wrap", 64'(row), 64'h01);
    wait_frame(cyc);
    check("t1_period", 64'(cyc), 64'd32);
    check("t1_keys", keys, 64'h0);
    check("t1_no_ev", 64'(ev_count), 64'd0);

    // key 10 held: keys update on third frame, one press event
    pressed = K10;
    do_reset();
    base = ev_count;
    wait_frame(cyc);
    check("t2_keys_f1", keys, 64'h0);
    wait_frame(cyc);
    check("t2_keys_f2", keys, 64'h0);
    exp_q.push_back(7'h4A);
    wait_frame(cyc);
    check("t2_keys_f3", keys, K10);
    check("t2_valid_0", 64'(ev_if.ev_valid), 64'h0);
    @(negedge clock);
    check("t2_valid_1", 64'(ev_if.ev_valid), 64'h1);
    check("t2_code", 64'(ev_if.ev_code), 64'h4A);
    @(negedge clock);
    check("t2_valid_drop", 64'(ev_if.ev_valid), 64'h0);
    check("t2_ev_cnt", 64'(ev_count - base), 64'd1);

    // press, release, press x3: keys only after frame 5
    pressed = K10;
    do_reset();
    base = ev_count;
    wait_frame(cyc);
    pressed = '0;
    wait_frame(cyc);
    pressed = K10;
    wait_frames(2);
    check("t3_keys_f4", keys, 64'h0);
    exp_q.push_back(7'h4A);
    wait_frame(cyc);
    check("t3_keys_f5", keys, K10);
    repeat (4) @(negedge clock);
    check("t3_ev_cnt", 64'(ev_count - base), 64'd1);

    // two keys with back-pressure: lowest index first, held stable
    ev_if.ev_ready = 1'b0;
    pressed = K5 | K63;
    do_reset();
    base = ev_count;
    wait_frames(3);
    check("t4_keys", keys, K5 | K63);
    repeat (2) @(negedge clock);
    check("t4_valid", 64'(ev_if.ev_valid), 64'h1);
    check("t4_code", 64'(ev_if.ev_code), 64'h45);
    hold_bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 7'h45) hold_bad++;
    end
    check("t4_hold", 64'(hold_bad), 64'd0);
    check("t4_no_accept", 64'(ev_count - base), 64'd0);
    exp_q.push_back(7'h45);
    exp_q.push_back(7'h7F);
    ev_if.ev_ready = 1'b1;
    repeat (6) @(negedge clock);
    check("t4_ev_cnt", 64'(ev_count - base), 64'd2);
    check("t4_valid_end", 64'(ev_if.ev_valid), 64'h0);

    // en=0 mid-frame at row 0x10, then restart
    wait_frame(cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (row !== 8'h10 && cyc < 40);
    check("t5_row10", 64'(row), 64'h10);
    en = 1'b0;
    @(negedge clock);
    check("t5_row_off", 64'(row), 64'h0);
    check("t5_state", 64'(scan_state), 64'(SCAN_IDLE));
    check("t5_keys_kept", keys, K5 | K63);
    fd_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (frame_done === 1'b1) fd_seen++;
    end
    check("t5_no_fd", 64'(fd_seen), 64'd0);
    en = 1'b1;
    @(negedge clock);
    check("t5_row_restart", 64'(row), 64'h01);
    check("t5_state_run", 64'(scan_state), 64'(SCAN_RUN));
    wait_frame(cyc);
    check("t5_full_frame", 64'(cyc), 64'd32);
    check("t5_keys_after", keys, K5 | K63);

    // reset with an event pending
    wait_frame(cyc);
    pressed = K5;
    ev_if.ev_ready = 1'b0;
    base = ev_count;
    wait_frames(3);
    check("t6_keys", keys, K5);
    repeat (2) @(negedge clock);
    check("t6_valid", 64'(ev_if.ev_valid), 64'h1);
    check("t6_code", 64'(ev_if.ev_code), 64'h3F);
    reset = 1'b1;
    @(negedge clock);
    check("t6_rst_row",   64'(row),            64'h0);
    check("t6_rst_keys",  keys,                64'h0);
    check("t6_rst_fd",    64'(frame_done),     64'h0);
    check("t6_rst_valid", 64'(ev_if.ev_valid), 64'h0);
    check("t6_rst_code",  64'(ev_if.ev_code),  64'h0);
    reset = 1'b0;
    pressed = '0;
    ev_if.ev_ready = 1'b1;
    wait_frames(4);
    check("t6_keys_quiet", keys, 64'h0);
    check("t6_no_ev", 64'(ev_count - base), 64'd0);
    pressed = K5;
    exp_q.push_back(7'h45);
    wait_frames(3);
    repeat (4) @(negedge clock);
    check("t6_keys_new", keys, K5);
    check("t6_ev_new", 64'(ev_count - base), 64'd1);

    // final report
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/key_matrix_scan.md
KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 Parameter SETTLE, default 4: clock cycles each row is driven; legal range 3..255.
REQ-002 Parameter DEBOUNCE, default 3: consecutive identical frames required before the stable bitmap updates; legal range 1..15.
REQ-003 clock  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  scan enable; 1 = scanning, 0 = idle.
REQ-006 column_in  input  8  asynchronous matrix column sense; 1 = key closed on the driven row.
REQ-007 row  output  8  one-hot row drive, registered, active-high.
REQ-008 keys  output  64  debounced bitmap; bit 8*r+c = row r, column c.
REQ-009 frame_done  output  1  one-cycle pulse at the end of every completed frame.
REQ-010 ev_valid  output  1  key-change event available.
REQ-011 ev_ready  input  1  consumer accepts event.
REQ-012 ev_code  output  7  event: bit 6 = 1 press / 0 release; bits 5:0 = key index 8*r+c.

Function
REQ-013 column_in SHALL pass through a 2-flop synchronizer before any use.
REQ-014 With en=1, row SHALL step 8'h01, 8'h02 ... 8'h80, then wrap to 8'h01, holding each value exactly SETTLE cycles; frame length = 8*SETTLE cycles.
REQ-015 The synchronized columns SHALL be sampled on the last cycle of each row period into raw-frame bits [8r+7:8r].
REQ-016 On the cycle row 7 is sampled, frame_done SHALL pulse high in the following cycle.
REQ-017 At frame end, if the raw frame equals the previous raw frame, the match counter increments (saturating at DEBOUNCE); otherwise it clears to 0.
REQ-018 keys SHALL load the raw frame at frame end when the frame has been seen in DEBOUNCE consecutive frames (counter+1 >= DEBOUNCE); DEBOUNCE=1 loads every frame.
REQ-019 en=0 SHALL drive row=0 in the next cycle, reset the row pointer and row-period counter, clear the match counter and raw frame, and retain keys; no frame_done while idle.
REQ-020 en 0->1 SHALL start a fresh frame at row 0; a frame interrupted by en=0 SHALL never update keys.
REQ-021 The block SHALL hold a 64-bit reported register; diff = keys XOR reported.
REQ-022 When ev_valid=0 and diff is nonzero, the next cycle SHALL assert ev_valid with ev_code = {keys[i], i}, i = lowest set index of diff.
REQ-023 While ev_valid=1 and ev_ready=0, ev_valid and ev_code SHALL hold stable even if keys changes.
REQ-024 On ev_valid=1 and ev_ready=1: reported[i] <= ev_code[6]; ev_valid deasserts next cycle; throughput at most one event per 2 cycles.
REQ-025 A key that toggles and returns before its event is generated SHALL produce no event; an issued event whose key reverts SHALL be followed by the reverse event.
REQ-026 keys update and event handshake in the same cycle SHALL both take effect; diff re-evaluated next cycle.

Reset
REQ-027 reset SHALL force row=0, keys=0, reported=0, frame_done=0, ev_valid=0, ev_code=0, synchronizer=0, raw frame=0, all counters 0, row pointer 0.
REQ-028 reset SHALL override en and ev_ready; mid-frame reset discards the partial frame; first cycle after release with en=1 drives row=8'h01.

Structure
REQ-029 Package key_matrix_pkg SHALL hold ROWS=8, COLS=8, KEY_IDX_W=6, EV_CODE_W=7 and the ev_code field positions.
REQ-030 The lowest-set-bit search SHALL be a sub-module prio_enc64 (64-bit in, 6-bit index, any flag), combinational.

Verification
REQ-031 SETTLE=4: reset, en=1, column_in=0 -> row 01,02,...,80 each 4 cycles, frame_done every 32 cycles, keys=0, no events.
REQ-032 DEBOUNCE=3, column_in=8'h04 only while row=8'h02 -> keys[10]=1 at end of 3rd frame; ev_valid with ev_code=7'h4A; ev_ready=1 -> ev_valid low next cycle.
REQ-033 Key 10 pressed on frame 1, released frame 2, pressed frames 3-5 -> keys[10] sets only after frame 5; exactly one press event.
REQ-034 Keys 5 and 63 pressed, ev_ready=0 for 100 cycles -> ev_code=7'h45 held; release ev_ready -> 7'h45 then 7'h7F accepted, 2 events total.
REQ-035 en=0 mid-frame at row 8'h10 -> row=0 next cycle, keys unchanged, no frame_done; en=1 -> row=8'h01 and full frame restarts.
REQ-036 reset pulse with ev_valid=1 and keys nonzero -> all outputs 0 next cycle, no event after release until a new debounced change.
